// File: rtl/data_cache_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache.
// The cache uses the slave view. A CPU/memory model or bench uses the master view.
interface data_cache_if;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache.
// A miss stalls the CPU, writes back a dirty victim, then fetches a 4-byte block.
module data_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic        clock,
  input  logic        reset,
  data_cache_if.slave bus
);
  localparam int TAG_BITS = 6 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [LINES-1:0]    valid_q, dirty_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] line_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  req, hit, write_hit, fill_done;

  assign offset     = bus.address[1:0];
  assign line_index = bus.address[INDEX_BITS+1:2];
  assign req_tag    = bus.address[7:INDEX_BITS+2];

  // read and write together is not treated as a request
  assign req       = bus.read ^ bus.write;
  assign hit       = valid_q[line_index] && (tag_q[line_index] == req_tag);
  assign write_hit = (state_q == IDLE) && hit && bus.write && !bus.read;
  assign fill_done = (state_q == MEM_READ) && !bus.mem_busywait;

  assign bus.busywait = req && !((state_q == IDLE) && hit);
  assign bus.readdata = data_q[line_index][{offset, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          state_d = dirty_q[line_index] ? MEM_WRITE : MEM_READ;
        end
      end
      MEM_WRITE: begin
        if (!bus.mem_busywait) begin
          state_d = MEM_READ;
        end
      end
      MEM_READ: begin
        if (!bus.mem_busywait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    case (state_q)
      MEM_WRITE: begin
        bus.mem_write     = 1'b1;
        bus.mem_address   = {tag_q[line_index], line_index};
        bus.mem_writedata = data_q[line_index];
      end
      MEM_READ: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {req_tag, line_index};
      end
      default: ;
    endcase
  end

  // A fill leaves the line clean. The pending access then completes as a hit in the next IDLE cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (write_hit) begin
        data_q[line_index][{offset, 3'b000} +: 8] <= bus.writedata;
        dirty_q[line_index] <= 1'b1;
      end
      if (fill_done) begin
        data_q[line_index]  <= bus.mem_readdata;
        tag_q[line_index]   <= req_tag;
        valid_q[line_index] <= 1'b1;
        dirty_q[line_index] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache.
// The bench plays both the CPU and the memory, and checks against hand-computed values.
module tb_data_cache;
  logic clock;
  logic reset;
  int   checkCount;
  int   passCount;

  data_cache_if bus ();

  data_cache #(.INDEX_BITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [7:0] addr, input logic [7:0] wdata);
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = addr;
    bus.writedata = wdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  initial begin
    logic [7:0] hitAddr [3];
    logic [7:0] hitData [3];
    hitAddr[0] = 8'h01; hitData[0] = 8'h22;
    hitAddr[1] = 8'h02; hitData[1] = 8'h33;
    hitAddr[2] = 8'h03; hitData[2] = 8'h44;

    checkCount = 0;
    passCount  = 0;
    reset      = 1'b0;
    bus.mem_busywait = 1'b1;
    bus.mem_readdata = '0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("rst_busywait", {31'b0, bus.busywait}, 32'h0);
    checkOutput("rst_mem_read", {31'b0, bus.mem_read}, 32'h0);
    checkOutput("rst_mem_write", {31'b0, bus.mem_write}, 32'h0);
    checkOutput("rst_mem_address", {26'b0, bus.mem_address}, 32'h0);
    checkOutput("rst_mem_writedata", bus.mem_writedata, 32'h0);
    checkOutput("rst_readdata", {24'b0, bus.readdata}, 32'h0);
    reset = 1'b1;
    tick();

    // cold miss on 0x00 with two cycles of memory latency
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("miss0_busywait", {31'b0, bus.busywait}, 32'h1);
    tick();
    checkOutput("miss0_mem_read", {31'b0, bus.mem_read}, 32'h1);
    checkOutput("miss0_mem_write", {31'b0, bus.mem_write}, 32'h0);
    checkOutput("miss0_mem_address", {26'b0, bus.mem_address}, 32'h00);
    tick();
    checkOutput("miss0_wait_busy", {31'b0, bus.busywait}, 32'h1);
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = 32'h44332211;
    tick();
    checkOutput("fill0_readdata", {24'b0, bus.readdata}, 32'h11);
    checkOutput("fill0_busywait", {31'b0, bus.busywait}, 32'h0);
    checkOutput("fill0_mem_read", {31'b0, bus.mem_read}, 32'h0);
    bus.mem_busywait = 1'b1;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, hitAddr[i], 8'h00);
      checkOutput($sformatf("hit_rd%0d_data", i), {24'b0, bus.readdata}, {24'b0, hitData[i]});
      checkOutput($sformatf("hit_rd%0d_busy", i), {31'b0, bus.busywait}, 32'h0);
      tick();
      checkOutput($sformatf("hit_rd%0d_mem_read", i), {31'b0, bus.mem_read}, 32'h0);
    end

    applyStimulus(1'b0, 1'b1, 8'h02, 8'hAA);
    checkOutput("wr_hit_busywait", {31'b0, bus.busywait}, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h02, 8'h00);
    checkOutput("wr_hit_readback", {24'b0, bus.readdata}, 32'hAA);
    checkOutput("wr_hit_no_mem_write", {31'b0, bus.mem_write}, 32'h0);
    tick();

    // conflict miss on the dirty line: write-back, then fetch
    applyStimulus(1'b1, 1'b0, 8'h22, 8'h00);
    checkOutput("evict_busywait", {31'b0, bus.busywait}, 32'h1);
    tick();
    checkOutput("evict_mem_write", {31'b0, bus.mem_write}, 32'h1);
    checkOutput("evict_mem_read", {31'b0, bus.mem_read}, 32'h0);
    checkOutput("evict_mem_address", {26'b0, bus.mem_address}, 32'h00);
    checkOutput("evict_mem_writedata", bus.mem_writedata, 32'h44AA2211);
    bus.mem_busywait = 1'b0;
    tick();
    checkOutput("refetch_mem_read", {31'b0, bus.mem_read}, 32'h1);
    checkOutput("refetch_mem_write", {31'b0, bus.mem_write}, 32'h0);
    checkOutput("refetch_mem_address", {26'b0, bus.mem_address}, 32'h08);
    bus.mem_readdata = 32'hDDCCBBAA;
    tick();
    checkOutput("refetch_readdata", {24'b0, bus.readdata}, 32'hCC);
    checkOutput("refetch_busywait", {31'b0, bus.busywait}, 32'h0);
    tick();

    applyStimulus(1'b1, 1'b1, 8'h21, 8'h55);
    checkOutput("rdwr_busywait", {31'b0, bus.busywait}, 32'h0);
    tick();
    checkOutput("rdwr_mem_read", {31'b0, bus.mem_read}, 32'h0);
    checkOutput("rdwr_mem_write", {31'b0, bus.mem_write}, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h21, 8'h00);
    checkOutput("rdwr_unchanged", {24'b0, bus.readdata}, 32'hBB);
    tick();

    // write miss allocates line 1, then the store lands on the filled block
    applyStimulus(1'b0, 1'b1, 8'h05, 8'h77);
    checkOutput("wmiss_busywait", {31'b0, bus.busywait}, 32'h1);
    tick();
    checkOutput("wmiss_mem_read", {31'b0, bus.mem_read}, 32'h1);
    checkOutput("wmiss_mem_address", {26'b0, bus.mem_address}, 32'h01);
    bus.mem_readdata = 32'h0C0B0A09;
    tick();
    checkOutput("wmiss_fill_busy", {31'b0, bus.busywait}, 32'h0);
    checkOutput("wmiss_fill_old", {24'b0, bus.readdata}, 32'h0A);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
    checkOutput("wmiss_store", {24'b0, bus.readdata}, 32'h77);
    applyStimulus(1'b1, 1'b0, 8'h06, 8'h00);
    checkOutput("wmiss_neighbour", {24'b0, bus.readdata}, 32'h0B);
    tick();

    // clean victim goes straight to MEM_READ; reset there aborts the fetch
    bus.mem_busywait = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h02, 8'h00);
    checkOutput("clean_busywait", {31'b0, bus.busywait}, 32'h1);
    tick();
    checkOutput("clean_mem_read", {31'b0, bus.mem_read}, 32'h1);
    checkOutput("clean_mem_write", {31'b0, bus.mem_write}, 32'h0);
    checkOutput("clean_mem_address", {26'b0, bus.mem_address}, 32'h00);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h02, 8'h00);
    tick();
    checkOutput("abort_mem_read", {31'b0, bus.mem_read}, 32'h0);
    checkOutput("abort_busywait", {31'b0, bus.busywait}, 32'h0);
    checkOutput("abort_readdata", {24'b0, bus.readdata}, 32'h0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("reread_busywait", {31'b0, bus.busywait}, 32'h1);
    tick();
    checkOutput("reread_mem_read", {31'b0, bus.mem_read}, 32'h1);
    checkOutput("reread_mem_write", {31'b0, bus.mem_write}, 32'h0);
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = 32'h11223344;
    tick();
    checkOutput("reread_readdata", {24'b0, bus.readdata}, 32'h44);
    checkOutput("reread_done", {31'b0, bus.busywait}, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
    checkOutput("reset_dirty_lost", {31'b0, bus.busywait}, 32'h1);
    tick();
    checkOutput("reset_no_writeback", {31'b0, bus.mem_write}, 32'h0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
